// File: rtl/vga_pmod_pkg.sv
// Shared constants for the TinyVGA PMOD output stage: Bayer matrix,
// PMOD bit positions, timing payload and reset value helper.
package vga_pmod_pkg;

    // uo_out bit positions: {R1,G1,B1,VS,R0,G0,B0,HS}
    localparam int unsigned PMOD_HS = 0;
    localparam int unsigned PMOD_B0 = 1;
    localparam int unsigned PMOD_G0 = 2;
    localparam int unsigned PMOD_R0 = 3;
    localparam int unsigned PMOD_VS = 4;
    localparam int unsigned PMOD_B1 = 5;
    localparam int unsigned PMOD_G1 = 6;
    localparam int unsigned PMOD_R1 = 7;

    // 4x4 ordered-dither thresholds, indexed [y][x]
    localparam logic [3:0] BAYER [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    // Timing signals travelling together through the sync pipeline
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } vid_timing_t;

    // Idle PMOD value: colour off, both syncs at their inactive level
    function automatic logic [7:0] pmod_reset_val(input logic active_low);
        logic [7:0] v;
        v          = 8'h00;
        v[PMOD_HS] = active_low;
        v[PMOD_VS] = active_low;
        return v;
    endfunction

endpackage

// File: rtl/vga_pmod_dither_out_if.sv
// Renderer/timing-generator video bus into the PMOD output stage.
interface vga_pmod_dither_out_if #(
    parameter int unsigned IN_BITS = 6
);
    logic               hsync_in;
    logic               vsync_in;
    logic               de_in;
    logic [IN_BITS-1:0] r_in;
    logic [IN_BITS-1:0] g_in;
    logic [IN_BITS-1:0] b_in;
    logic [1:0]         x_lsb;
    logic [1:0]         y_lsb;

    modport master (
        output hsync_in, vsync_in, de_in, r_in, g_in, b_in, x_lsb, y_lsb
    );

    modport slave (
        input hsync_in, vsync_in, de_in, r_in, g_in, b_in, x_lsb, y_lsb
    );
endinterface

// File: rtl/vga_chan_dither.sv
// One colour channel: reduce IN_BITS to 2 bits with a Bayer threshold.
// Purely combinational; the parent registers the result.
module vga_chan_dither #(
    parameter int unsigned IN_BITS = 6
) (
    input  logic [IN_BITS-1:0] c,
    input  logic [3:0]         thr,
    input  logic               dither_en,
    output logic [1:0]         val_c
);

    if (IN_BITS == 2) begin : g_pass
        // Already 2 bits wide: nothing to dither
        logic unused_ok;
        assign unused_ok = ^{thr, dither_en};
        assign val_c     = c;
    end else begin : g_dither
        localparam int unsigned F     = IN_BITS - 2;
        localparam int unsigned SH_UP = (F >= 4) ? F - 4 : 0;
        localparam int unsigned SH_DN = (F >= 4) ? 0 : 4 - F;
        localparam int unsigned TW    = 12;

        logic [1:0]    hi;
        logic [F-1:0]  frac;
        logic [TW-1:0] t_scaled;
        logic          bump;

        assign hi       = c[IN_BITS-1 -: 2];
        assign frac     = c[F-1:0];
        // Stretch or shrink the 4-bit threshold to the fraction width
        assign t_scaled = (TW'(thr) << SH_UP) >> SH_DN;
        assign bump     = dither_en && (TW'(frac) > t_scaled);
        // Saturating round-up: full scale never wraps to black
        assign val_c    = (bump && (hi != 2'd3)) ? hi + 2'd1 : hi;
    end

endmodule

// File: rtl/vga_pmod_dither_out.sv
// TinyVGA PMOD output stage: wide colour -> 2 bits/channel with ordered
// (optionally temporal) Bayer dither, sync/DE alignment and blanking.
// Optional test-pattern bars are compiled in with VGA_PMOD_TESTPAT_EN.
module vga_pmod_dither_out
    import vga_pmod_pkg::*;
#(
    parameter int unsigned IN_BITS         = 6,
    parameter int unsigned SYNC_SKEW       = 0,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_pmod_dither_out_if.slave  vin,
    input  logic                  dither_en,
    input  logic                  temporal_en,
    input  logic                  test_en,
    output logic [7:0]            uo_out
);

    localparam logic        SYNC_IDLE = SYNC_ACTIVE_LOW;
    localparam logic        SYNC_ACT  = ~SYNC_ACTIVE_LOW;
    localparam vid_timing_t TIM_RST   = '{hs: SYNC_IDLE, vs: SYNC_IDLE, de: 1'b0};
    localparam logic [7:0]  PMOD_RST  = pmod_reset_val(SYNC_ACTIVE_LOW);

    vid_timing_t        tin;
    vid_timing_t        t_al;
    vid_timing_t        t1;
    logic [IN_BITS-1:0] r_src, g_src, b_src;
    logic [IN_BITS-1:0] r1, g1, b1;
    logic [1:0]         x1, y1, ph1;
    logic               den1;
    logic [1:0]         frame_cnt;
    logic               vs_assert_c;
    logic [1:0]         xi_c, yi_c;
    logic [3:0]         thr_c;
    logic [1:0]         r_q_c, g_q_c, b_q_c;
    logic [7:0]         uo_next_c;

    assign tin = '{hs: vin.hsync_in, vs: vin.vsync_in, de: vin.de_in};

    if (SYNC_SKEW == 0) begin : g_noskew
        assign t_al = tin;
    end else begin : g_skew
        vid_timing_t skew_q [SYNC_SKEW];

        // Delay timing so it meets the late renderer colour
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < int'(SYNC_SKEW); i++) skew_q[i] <= TIM_RST;
            end else begin
                skew_q[0] <= tin;
                for (int i = 1; i < int'(SYNC_SKEW); i++) skew_q[i] <= skew_q[i-1];
            end
        end

        assign t_al = skew_q[SYNC_SKEW-1];
    end

`ifdef VGA_PMOD_TESTPAT_EN
    localparam int unsigned BAR_SHIFT = 6;
    localparam int unsigned PIX_W     = BAR_SHIFT + 3;

    logic [PIX_W-1:0] pix_cnt;
    logic [PIX_W-1:0] pix_idx_c;
    logic [2:0]       bar_c;

    // Visible-pixel index, restarting at every line start
    assign pix_idx_c = (t_al.de && !t1.de) ? '0 : pix_cnt;
    assign bar_c     = pix_idx_c[PIX_W-1 -: 3];

    // Advance the bar pixel counter across the visible area
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pix_cnt <= '0;
        else if (t_al.de) pix_cnt <= PIX_W'(pix_idx_c + 1'b1);
    end

    // Substitute full-scale colour bars when the pattern is selected
    always_comb begin
        r_src = vin.r_in;
        g_src = vin.g_in;
        b_src = vin.b_in;
        if (test_en) begin
            r_src = {IN_BITS{bar_c[2]}};
            g_src = {IN_BITS{bar_c[1]}};
            b_src = {IN_BITS{bar_c[0]}};
        end
    end
`else
    logic unused_test_en;
    assign unused_test_en = test_en;
    assign r_src          = vin.r_in;
    assign g_src          = vin.g_in;
    assign b_src          = vin.b_in;
`endif

    // Frame boundary = assertion edge of the aligned vsync
    assign vs_assert_c = (t_al.vs == SYNC_ACT) && (t1.vs != SYNC_ACT);

    // Stage 1: capture colour, position, controls and aligned timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1        <= TIM_RST;
            r1        <= '0;
            g1        <= '0;
            b1        <= '0;
            x1        <= '0;
            y1        <= '0;
            ph1       <= '0;
            den1      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            t1   <= t_al;
            r1   <= r_src;
            g1   <= g_src;
            b1   <= b_src;
            x1   <= vin.x_lsb;
            y1   <= vin.y_lsb;
            ph1  <= temporal_en ? frame_cnt : 2'd0;
            den1 <= dither_en;
            if (vs_assert_c) frame_cnt <= frame_cnt + 2'd1;
        end
    end

    assign xi_c  = 2'(x1 + ph1);
    assign yi_c  = 2'(y1 + ph1);
    assign thr_c = BAYER[yi_c][xi_c];

    vga_chan_dither #(.IN_BITS(IN_BITS)) u_dith_r (
        .c(r1), .thr(thr_c), .dither_en(den1), .val_c(r_q_c)
    );
    vga_chan_dither #(.IN_BITS(IN_BITS)) u_dith_g (
        .c(g1), .thr(thr_c), .dither_en(den1), .val_c(g_q_c)
    );
    vga_chan_dither #(.IN_BITS(IN_BITS)) u_dith_b (
        .c(b1), .thr(thr_c), .dither_en(den1), .val_c(b_q_c)
    );

    // Map to PMOD pins; colour is forced dark outside the visible area
    always_comb begin
        uo_next_c          = 8'h00;
        uo_next_c[PMOD_HS] = t1.hs;
        uo_next_c[PMOD_VS] = t1.vs;
        if (t1.de) begin
            uo_next_c[PMOD_R1] = r_q_c[1];
            uo_next_c[PMOD_R0] = r_q_c[0];
            uo_next_c[PMOD_G1] = g_q_c[1];
            uo_next_c[PMOD_G0] = g_q_c[0];
            uo_next_c[PMOD_B1] = b_q_c[1];
            uo_next_c[PMOD_B0] = b_q_c[0];
        end
    end

    // Stage 2: registered PMOD output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) uo_out <= PMOD_RST;
        else        uo_out <= uo_next_c;
    end

endmodule

// File: tb/tb_vga_pmod_dither_out.sv
// Directed bench for vga_pmod_dither_out: one instance with no sync skew
// and one with SYNC_SKEW=3, both driven by the same stimulus.
module tb_vga_pmod_dither_out;

    logic       clk;
    logic       rst_n;
    logic       hs, vs, de;
    logic [5:0] r, g, b;
    logic [1:0] x, y;
    logic       den, ten, tst;
    logic [7:0] uo0, uo3;

    int n_assert = 0;
    int n_fail   = 0;

    vga_pmod_dither_out_if #(.IN_BITS(6)) vif0 ();
    vga_pmod_dither_out_if #(.IN_BITS(6)) vif3 ();

    assign vif0.hsync_in = hs;
    assign vif0.vsync_in = vs;
    assign vif0.de_in    = de;
    assign vif0.r_in     = r;
    assign vif0.g_in     = g;
    assign vif0.b_in     = b;
    assign vif0.x_lsb    = x;
    assign vif0.y_lsb    = y;

    assign vif3.hsync_in = hs;
    assign vif3.vsync_in = vs;
    assign vif3.de_in    = de;
    assign vif3.r_in     = r;
    assign vif3.g_in     = g;
    assign vif3.b_in     = b;
    assign vif3.x_lsb    = x;
    assign vif3.y_lsb    = y;

    vga_pmod_dither_out #(.IN_BITS(6), .SYNC_SKEW(0), .SYNC_ACTIVE_LOW(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .vin(vif0), .dither_en(den),
        .temporal_en(ten), .test_en(tst), .uo_out(uo0)
    );

    vga_pmod_dither_out #(.IN_BITS(6), .SYNC_SKEW(3), .SYNC_ACTIVE_LOW(1'b1)) dut3 (
        .clk(clk), .rst_n(rst_n), .vin(vif3), .dither_en(den),
        .temporal_en(ten), .test_en(tst), .uo_out(uo3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // uo_out = 0x11 idle; R adds 0x08/0x80, G 0x04/0x40, B 0x02/0x20
    logic [7:0] exp14 [5];
    logic [7:0] exp11 [5];

    initial begin
        exp14 = '{8'h91, 8'h19, 8'h91, 8'h19, 8'h91};
        exp11 = '{8'h91, 8'h19, 8'h19, 8'h19, 8'h91};

        rst_n = 1'b0;
        hs = 1'b1; vs = 1'b1; de = 1'b1;
        r = 6'h3F; g = 6'h00; b = 6'h00; x = 2'd0; y = 2'd0;
        den = 1'b1; ten = 1'b0; tst = 1'b0;

        // Reset holds the idle value even with live colour present
        tick(3);
        chk("reset_dut0", uo0, 8'h11);
        chk("reset_dut3", uo3, 8'h11);

        // First update lands on the second edge after release
        rst_n = 1'b1;
        tick(1);
        chk("release_edge1", uo0, 8'h11);
        tick(1);
        chk("release_edge2", uo0, 8'h99);

        // Spatial dither, frame 0, no temporal shift
        r = 6'b01_1000;
        tick(2); chk("dither_x0y0", uo0, 8'h91);
        x = 2'd1;
        tick(2); chk("dither_x1y0", uo0, 8'h19);
        x = 2'd0; y = 2'd1;
        tick(2); chk("dither_x0y1", uo0, 8'h19);
        x = 2'd3; y = 2'd3; r = 6'b01_0110;
        tick(2); chk("dither_x3y3_above", uo0, 8'h91);
        r = 6'b01_0101;
        tick(2); chk("dither_x3y3_equal", uo0, 8'h19);
        x = 2'd0; y = 2'd0; r = 6'b01_1000; g = 6'h3F; b = 6'b10_1111;
        tick(2); chk("dither_rgb", uo0, 8'hF7);

        // Saturation and truncation
        x = 2'd1; y = 2'd2; r = 6'h3F; g = 6'h00; b = 6'h00;
        tick(2); chk("saturate", uo0, 8'h99);
        den = 1'b0; x = 2'd0; y = 2'd0; r = 6'b10_1111; g = 6'b01_1000;
        tick(2); chk("truncate", uo0, 8'h95);

        // Blanking keeps syncs but darkens colour
        den = 1'b1; r = 6'h3F; g = 6'h00; de = 1'b0;
        tick(2); chk("blank_dut0", uo0, 8'h11);
        de = 1'b1;
        tick(6);
        chk("steady_dut0", uo0, 8'h99);
        chk("steady_dut3", uo3, 8'h99);

        // One-cycle de/hsync pulse: latency 2 without skew, 5 with skew 3
        de = 1'b0; hs = 1'b0;
        tick(1);
        de = 1'b1; hs = 1'b1;
        chk("align_dut0_c1", uo0, 8'h99);
        tick(1); chk("align_dut0_c2", uo0, 8'h10);
        tick(1); chk("align_dut0_c3", uo0, 8'h99);
        tick(1); chk("align_dut3_c4", uo3, 8'h99);
        tick(1); chk("align_dut3_c5", uo3, 8'h10);
        tick(1); chk("align_dut3_c6", uo3, 8'h99);

        // Temporal dither across frames 0,1,2,3 and the wrap back to 0
        ten = 1'b1; x = 2'd0; y = 2'd0;
        for (int f = 0; f < 5; f++) begin
            if (f > 0) begin
                vs = 1'b0;
                tick(1);
                vs = 1'b1;
            end
            r = 6'b01_1000; tick(2); chk($sformatf("temporal_f%0d_r18", f), uo0, 8'h91);
            r = 6'b01_0100; tick(2); chk($sformatf("temporal_f%0d_r14", f), uo0, exp14[f]);
            r = 6'b01_0001; tick(2); chk($sformatf("temporal_f%0d_r11", f), uo0, exp11[f]);
        end

        // temporal_en=0 pins the phase at 0 even in frame 1
        vs = 1'b0; tick(1); vs = 1'b1;
        r = 6'b01_0100;
        tick(2); chk("frame1_temporal_on", uo0, 8'h19);
        ten = 1'b0;
        tick(2); chk("frame1_temporal_off", uo0, 8'h91);
        ten = 1'b1;
        tick(2); chk("frame1_temporal_back", uo0, 8'h19);

        // Mid-frame async reset forces idle at once and clears frame_cnt
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_dut0", uo0, 8'h11);
        chk("midreset_dut3", uo3, 8'h11);
        tick(1);
        rst_n = 1'b1;
        tick(1); chk("midreset_edge1", uo0, 8'h11);
        tick(1); chk("midreset_edge2_frame0", uo0, 8'h91);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pmod_dither_out.md
Name: vga_pmod_dither_out

Overview:
Parametrised TinyVGA PMOD output stage, successor to the fixed 2-bit RGB pin mapper. It accepts wide per-channel colour from any renderer and reduces it to 2 bits per channel with ordered 4x4 Bayer dithering, optionally shifted each frame (temporal dither). It aligns sync and data-enable to the colour pipeline, forces blanking, and drives the 8-bit PMOD bus. It sits between renderer and uo_out in every tt_um_* top.

Parameters:
IN_BITS, 6, colour bits per channel input (2..8); 2 means pass-through with no dither logic.
SYNC_SKEW, 0, extra cycles that timing inputs are delayed so they align with late renderer colour (0..7).
SYNC_ACTIVE_LOW, 1, polarity of hsync_in/vsync_in and of the output syncs (1 = active-low).

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
hsync_in  in  1  horizontal sync from timing generator
vsync_in  in  1  vertical sync from timing generator
de_in  in  1  display-enable (visible area) from timing generator
r_in  in  IN_BITS  red, aligned SYNC_SKEW cycles after timing inputs
g_in  in  IN_BITS  green, same alignment
b_in  in  IN_BITS  blue, same alignment
x_lsb  in  2  pixel x[1:0], aligned with colour
y_lsb  in  2  pixel y[1:0], aligned with colour
dither_en  in  1  1 = Bayer dither, 0 = truncate to top 2 bits
temporal_en  in  1  1 = shift dither matrix per frame
test_en  in  1  test-pattern select (used only with the optional feature)
uo_out  out  8  {R1,G1,B1,VS,R0,G0,B0,HS}

Behaviour:
- Reset: all pipeline registers are cleared. uo_out colour bits are 0 and sync bits are at the inactive level, so uo_out = 8'b0001_0001 when SYNC_ACTIVE_LOW=1 and 8'h00 otherwise. frame_cnt is 0.
- Timing path: hsync_in, vsync_in and de_in pass through a SYNC_SKEW-deep shift register, then through 2 more stages. Total latency is SYNC_SKEW+2.
- Colour path: stage 1 registers r/g/b, x_lsb, y_lsb and the aligned de. Stage 2 computes the dithered value and registers uo_out. Latency is 2.
- Dither per channel: F = IN_BITS-2. hi = c[IN_BITS-1:F], frac = c[F-1:0].
- Bayer index: xi = x_lsb + ph, yi = y_lsb + ph (mod 4). ph = frame_cnt when temporal_en=1, else 0.
- Threshold: t = BAYER[yi][xi] (0..15). Scale t to F bits: t<<(F-4) if F>=4, else t>>(4-F).
- Output: out = hi + (frac > t_scaled). The sum saturates at 3, so hi=3 stays 3.
- dither_en=0: out = hi.
- IN_BITS=2: out = c. dither_en and temporal_en are ignored.
- Blanking: if the aligned de is 0 at stage 2, all colour bits are 0 regardless of input. Syncs are unaffected.
- frame_cnt: 2-bit counter that increments on the assertion edge of the aligned vsync (falling edge when active-low). It is sampled at stage 1 and wraps 3 -> 0.
- dither_en and temporal_en are sampled at stage 1. A change mid-line takes effect 2 cycles later, with no glitch on syncs.
- Reset asserted mid-frame immediately forces the reset value and clears frame_cnt. After release, the first uo_out update occurs on the second clk edge.

Optional Feature:
Macro VGA_PMOD_TESTPAT_EN.
- Defined: when test_en=1, stage-1 colour is replaced by 8 vertical colour bars. The bars come from an internal 3-bit bar counter that advances every 2^(BAR_SHIFT) visible pixels (BAR_SHIFT=6 localparam) and resets on each de rising edge. Bar k = {R,G,B} = {k[2],k[1],k[0]} at full scale. The dither, blanking and timing paths are unchanged.
- Undefined: test_en is ignored. No counter logic is generated.

Decomposition:
- Package vga_pmod_pkg holds the 4x4 BAYER constant array {0,8,2,10; 12,4,14,6; 3,11,1,9; 15,7,13,5}, the PMOD bit-position localparams and the uo_out reset constant function of polarity.
- Sub-module vga_chan_dither (one instance per channel): implements the threshold scaling, compare and saturating add for one channel. It is parametrised by IN_BITS and is combinational, registered by the parent.

Test Plan:
- Reset value: IN_BITS=6, SYNC_ACTIVE_LOW=1, hold rst_n=0 -> uo_out = 8'h11. Release rst_n -> input colour appears on uo_out after exactly 2 edges.
- Spatial dither: r_in=6'b01_1000, dither_en=1, temporal_en=0, frame_cnt=0. (x,y)=(0,0) gives threshold 0, R=2'b10. (1,0) gives threshold 8, R=2'b01. (0,1) gives threshold 12, R=2'b01.
- Saturation and truncation: r_in=6'h3F, any x/y -> R=3. dither_en=0 with r_in=6'b10_1111 -> R=2.
- Blanking and alignment: SYNC_SKEW=3, de_in=0 pulse -> the colour bits of uo_out are 0 exactly in the cycles where the delayed de is low, and HS/VS edges appear SYNC_SKEW+2 cycles after the input edges.
- Temporal dither: temporal_en=1, r_in=6'b01_1000 at (0,0). Frame_cnt values 0,1,2,3 give thresholds 0,4,1,5 respectively, so R=2 in every frame. After 4 vsync assertions frame_cnt wraps back to 0.
- Optional feature (macro defined): test_en=1, de_in high for 512 cycles -> uo_out colour steps through bars 0..7, changing every 64 pixels. Bar 7 gives R=G=B=3.
